vmask_seq: RTL and testbench

VMASK_SEQ -- requirements
Module: vmask_seq

---
 rtl/vmask_seq.sv | 219 +++++++++++++++++++++
 tb/tb_vmask_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmask_seq.sv
// vmask_seq: sequences one vector-mask command into per-beat register-file reads and
// forwards each in-order read response as one registered operand beat to the mask-op stage.
//
// Ports:
//   clk, rst (asynchronous, active-low)
//   cmd_*          command handshake; operand/destination base addresses, mask length
//                  in bits, op select
//   rd_req_*       read request port (valid/ready) with per-beat addresses rd_addr0/rd_addr1
//   rd_resp_valid  in-order read response with rd_data0/rd_data1
//   out_*          registered operand beat, no backpressure; fields are zero when invalid
//   busy           high whenever the sequencer is not idle
//
// Build option: define VMASK_TAIL_ZERO_EN to clear the bits past the mask length in the
// final beat when the length is not a multiple of the beat width.
module vmask_seq #(
  parameter int unsigned REQ_DATA_WIDTH  = 64,
  parameter int unsigned REQ_ADDR_WIDTH  = 32,
  parameter int unsigned OPSEL_WIDTH     = 3,
  parameter int unsigned VL_WIDTH        = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [REQ_ADDR_WIDTH-1:0] cmd_vs1_addr,
  input  logic [REQ_ADDR_WIDTH-1:0] cmd_vs2_addr,
  input  logic [REQ_ADDR_WIDTH-1:0] cmd_vd_addr,
  input  logic [VL_WIDTH-1:0]       cmd_vl,
  input  logic [OPSEL_WIDTH-1:0]    cmd_opSel,
  output logic                      rd_req_valid,
  input  logic                      rd_req_ready,
  output logic [REQ_ADDR_WIDTH-1:0] rd_addr0,
  output logic [REQ_ADDR_WIDTH-1:0] rd_addr1,
  input  logic                      rd_resp_valid,
  input  logic [REQ_DATA_WIDTH-1:0] rd_data0,
  input  logic [REQ_DATA_WIDTH-1:0] rd_data1,
  output logic [REQ_DATA_WIDTH-1:0] out_m0,
  output logic [REQ_DATA_WIDTH-1:0] out_m1,
  output logic [REQ_ADDR_WIDTH-1:0] out_addr,
  output logic [OPSEL_WIDTH-1:0]    out_opSel,
  output logic                      out_valid,
  output logic                      busy
);

  localparam int unsigned W  = REQ_DATA_WIDTH;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e state_q, state_d;

  logic [REQ_ADDR_WIDTH-1:0] vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
  logic [VL_WIDTH-1:0]       vl_q, vl_d;
  logic [OPSEL_WIDTH-1:0]    op_q, op_d;
  logic [VL_WIDTH-1:0]       k_q, k_d;    // next beat to request
  logic [VL_WIDTH-1:0]       j_q, j_d;    // next beat to return
  logic [OW-1:0]             outst_q, outst_d;

  logic                      out_valid_q, out_valid_d;
  logic [W-1:0]              out_m0_q, out_m0_d, out_m1_q, out_m1_d;
  logic [REQ_ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [OPSEL_WIDTH-1:0]    out_opsel_q, out_opsel_d;

  logic [VL_WIDTH-1:0] beats;
  logic                cmd_fire, req_fire, resp_take, last_req;
  logic [W-1:0]        tail_mask;

  // Beat count derived from the latched length: ceil(vl / W).
  assign beats = VL_WIDTH'((32'(vl_q) + W - 1) / W);

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign req_fire  = rd_req_valid & rd_req_ready;
  // Responses are only meaningful while a command is active and something is in flight.
  assign resp_take = rd_resp_valid & (state_q != StIdle) & (outst_q != '0);
  assign last_req  = (k_q == beats - VL_WIDTH'(1));

`ifdef VMASK_TAIL_ZERO_EN
  int unsigned tail_rem;
  always_comb begin
    tail_rem  = 32'(vl_q) % W;
    tail_mask = '1;
    if ((tail_rem != 0) && (j_q == beats - VL_WIDTH'(1))) begin
      for (int unsigned i = 0; i < W; i++) begin
        tail_mask[i] = (i < tail_rem);
      end
    end
  end
`else
  assign tail_mask = '1;
`endif

  // ---------------------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // A zero-length command passes through DRAIN for one cycle with nothing in flight.
        if (cmd_fire) state_d = (cmd_vl == '0) ? StDrain : StIssue;
      end
      StIssue: begin
        if (req_fire && last_req) state_d = StDrain;
      end
      StDrain: begin
        // Leave in the same edge that registers the final beat.
        if (outst_d == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs. cmd_ready is gated by rst so it stays low throughout reset.
  always_comb begin
    cmd_ready    = (state_q == StIdle) & rst;
    busy         = (state_q != StIdle);
    rd_req_valid = (state_q == StIssue) && (outst_q < OW'(MAX_OUTSTANDING));
    rd_addr0     = '0;
    rd_addr1     = '0;
    if (rd_req_valid) begin
      rd_addr0 = vs1_q + REQ_ADDR_WIDTH'(k_q);
      rd_addr1 = vs2_q + REQ_ADDR_WIDTH'(k_q);
    end
  end

  // ---------------------------------------------------------------------------------------
  // Datapath: command latch, counters, response register
  // ---------------------------------------------------------------------------------------
  always_comb begin
    vs1_d       = vs1_q;
    vs2_d       = vs2_q;
    vd_d        = vd_q;
    vl_d        = vl_q;
    op_d        = op_q;
    k_d         = k_q;
    j_d         = j_q;
    outst_d     = outst_q;
    out_valid_d = resp_take;
    out_m0_d    = '0;
    out_m1_d    = '0;
    out_addr_d  = '0;
    out_opsel_d = '0;

    if (cmd_fire) begin
      vs1_d = cmd_vs1_addr;
      vs2_d = cmd_vs2_addr;
      vd_d  = cmd_vd_addr;
      vl_d  = cmd_vl;
      op_d  = cmd_opSel;
      k_d   = '0;
      j_d   = '0;
    end

    if (req_fire) k_d = k_q + VL_WIDTH'(1);

    unique case ({req_fire, resp_take})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    if (resp_take) begin
      out_m0_d    = rd_data0 & tail_mask;
      out_m1_d    = rd_data1 & tail_mask;
      out_addr_d  = vd_q + REQ_ADDR_WIDTH'(j_q);
      out_opsel_d = op_q;
      j_d         = j_q + VL_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs1_q       <= '0;
      vs2_q       <= '0;
      vd_q        <= '0;
      vl_q        <= '0;
      op_q        <= '0;
      k_q         <= '0;
      j_q         <= '0;
      outst_q     <= '0;
      out_valid_q <= 1'b0;
      out_m0_q    <= '0;
      out_m1_q    <= '0;
      out_addr_q  <= '0;
      out_opsel_q <= '0;
    end else begin
      vs1_q       <= vs1_d;
      vs2_q       <= vs2_d;
      vd_q        <= vd_d;
      vl_q        <= vl_d;
      op_q        <= op_d;
      k_q         <= k_d;
      j_q         <= j_d;
      outst_q     <= outst_d;
      out_valid_q <= out_valid_d;
      out_m0_q    <= out_m0_d;
      out_m1_q    <= out_m1_d;
      out_addr_q  <= out_addr_d;
      out_opsel_q <= out_opsel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_m0    = out_m0_q;
  assign out_m1    = out_m1_q;
  assign out_addr  = out_addr_q;
  assign out_opSel = out_opsel_q;

endmodule

// File: tb/tb_vmask_seq.sv
// Directed self-checking bench for vmask_seq (default parameters). A responder process
// answers accepted reads in order after a programmable latency; a monitor logs accepted
// requests and output beats for the main sequence to compare against hand-computed values.
module tb_vmask_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_vs1_addr = '0, cmd_vs2_addr = '0, cmd_vd_addr = '0;
  logic [15:0] cmd_vl = '0;
  logic [2:0]  cmd_opSel = '0;
  logic        rd_req_valid;
  logic        rd_req_ready = 1'b0;
  logic [31:0] rd_addr0, rd_addr1;
  logic        rd_resp_valid = 1'b0;
  logic [63:0] rd_data0 = '0, rd_data1 = '0;
  logic [63:0] out_m0, out_m1;
  logic [31:0] out_addr;
  logic [2:0]  out_opSel;
  logic        out_valid;
  logic        busy;

  vmask_seq dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_vs1_addr (cmd_vs1_addr),
    .cmd_vs2_addr (cmd_vs2_addr),
    .cmd_vd_addr  (cmd_vd_addr),
    .cmd_vl       (cmd_vl),
    .cmd_opSel    (cmd_opSel),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_addr0     (rd_addr0),
    .rd_addr1     (rd_addr1),
    .rd_resp_valid(rd_resp_valid),
    .rd_data0     (rd_data0),
    .rd_data1     (rd_data1),
    .out_m0       (out_m0),
    .out_m1       (out_m1),
    .out_addr     (out_addr),
    .out_opSel    (out_opSel),
    .out_valid    (out_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a0;
    logic [31:0] a1;
    int          t;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] m0;
    logic [63:0] m1;
    logic [2:0]  op;
  } beat_t;

  req_t  pend[$];
  req_t  req_log[$];
  beat_t beat_log[$];

  int cyc = 0;
  int resp_lat = 2;
  bit resp_en = 1'b0;
  bit data_ones = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [63:0] d0_of(input logic [31:0] a);
    return data_ones ? '1 : {32'hA5A5_A5A5, a};
  endfunction

  function automatic logic [63:0] d1_of(input logic [31:0] a);
    return data_ones ? '1 : {32'h5A5A_5A5A, ~a};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Responder and monitor, both acting on the falling edge.
  always @(negedge clk) begin
    req_t r;
    beat_t b;
    if (rd_req_valid && rd_req_ready) begin
      r.a0 = rd_addr0;
      r.a1 = rd_addr1;
      r.t  = cyc;
      pend.push_back(r);
      req_log.push_back(r);
    end
    rd_resp_valid = 1'b0;
    rd_data0      = '0;
    rd_data1      = '0;
    if (resp_en && pend.size() > 0 && cyc >= pend[0].t + resp_lat) begin
      r = pend.pop_front();
      rd_resp_valid = 1'b1;
      rd_data0      = d0_of(r.a0);
      rd_data1      = d1_of(r.a1);
    end
    if (out_valid) begin
      b.addr = out_addr;
      b.m0   = out_m0;
      b.m1   = out_m1;
      b.op   = out_opSel;
      beat_log.push_back(b);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_log.delete();
    beat_log.delete();
  endtask

  task automatic issue_cmd(input logic [31:0] vs1, input logic [31:0] vs2,
                           input logic [31:0] vd, input logic [15:0] vl, input logic [2:0] op);
    cmd_vs1_addr = vs1;
    cmd_vs2_addr = vs2;
    cmd_vd_addr  = vd;
    cmd_vl       = vl;
    cmd_opSel    = op;
    cmd_valid    = 1'b1;
    check_eq("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check_eq("idle_within_budget", 64'(busy), 64'd0);
    repeat (2) tick();
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_rd_req_valid", 64'(rd_req_valid), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b1;
    tick();
    check_eq("cmd_ready_after_release", 64'(cmd_ready), 64'd1);

    // Single beat, 2-cycle response latency
    resp_en = 1'b1; rd_req_ready = 1'b1; resp_lat = 2; data_ones = 1'b0;
    clear_logs();
    issue_cmd(32'h10, 32'h20, 32'h30, 16'd64, 3'd3);
    check_eq("t1_busy", 64'(busy), 64'd1);
    wait_idle(50);
    check_eq("t1_nreq", 64'(req_log.size()), 64'd1);
    if (req_log.size() == 1) begin
      check_eq("t1_rd_addr0", 64'(req_log[0].a0), 64'h10);
      check_eq("t1_rd_addr1", 64'(req_log[0].a1), 64'h20);
    end
    check_eq("t1_nbeats", 64'(beat_log.size()), 64'd1);
    if (beat_log.size() == 1) begin
      check_eq("t1_out_addr", 64'(beat_log[0].addr), 64'h30);
      check_eq("t1_out_opsel", 64'(beat_log[0].op), 64'd3);
      check_eq("t1_out_m0", beat_log[0].m0, 64'hA5A5_A5A5_0000_0010);
      check_eq("t1_out_m1", beat_log[0].m1, 64'h5A5A_5A5A_FFFF_FFDF);
    end
    check_eq("t1_idle_out_m0_zero", out_m0, 64'd0);
    check_eq("t1_idle_out_addr_zero", 64'(out_addr), 64'd0);

    // vl=200 -> 4 beats, with an initial stall on rd_req_ready
    clear_logs();
    rd_req_ready = 1'b0;
    issue_cmd(32'h100, 32'h200, 32'h300, 16'd200, 3'd5);
    repeat (3) tick();
    check_eq("t2_stall_valid", 64'(rd_req_valid), 64'd1);
    check_eq("t2_stall_addr0", 64'(rd_addr0), 64'h100);
    check_eq("t2_stall_addr1", 64'(rd_addr1), 64'h200);
    rd_req_ready = 1'b1;
    wait_idle(100);
    check_eq("t2_nreq", 64'(req_log.size()), 64'd4);
    check_eq("t2_nbeats", 64'(beat_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < req_log.size()) check_eq("t2_rd_addr0", 64'(req_log[i].a0), 64'(32'h100 + i));
      if (i < beat_log.size()) begin
        check_eq("t2_out_addr", 64'(beat_log[i].addr), 64'(32'h300 + i));
        check_eq("t2_out_m1", beat_log[i].m1, {32'h5A5A_5A5A, ~(32'h200 + 32'(i))});
      end
    end

    // Address wrap
    clear_logs();
    issue_cmd(32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 16'd200, 3'd1);
    wait_idle(100);
    if (req_log.size() == 4) check_eq("wrap_rd_addr0_k2", 64'(req_log[2].a0), 64'd0);
    else check_eq("wrap_nreq", 64'(req_log.size()), 64'd4);
    if (beat_log.size() == 4) check_eq("wrap_out_addr_j1", 64'(beat_log[1].addr), 64'd0);
    else check_eq("wrap_nbeats", 64'(beat_log.size()), 64'd4);

    // Outstanding cap: responses withheld
    clear_logs();
    resp_en = 1'b0;
    issue_cmd(32'h1000, 32'h2000, 32'h3000, 16'd512, 3'd2);
    repeat (10) tick();
    check_eq("cap_nreq", 64'(req_log.size()), 64'd4);
    check_eq("cap_rd_req_valid", 64'(rd_req_valid), 64'd0);
    resp_en = 1'b1;
    wait_idle(200);
    check_eq("cap_total_nreq", 64'(req_log.size()), 64'd8);
    check_eq("cap_nbeats", 64'(beat_log.size()), 64'd8);
    if (beat_log.size() == 8) check_eq("cap_last_addr", 64'(beat_log[7].addr), 64'h3007);

    // vl=0
    clear_logs();
    issue_cmd(32'h40, 32'h50, 32'h60, 16'd0, 3'd4);
    check_eq("vl0_cmd_ready_low", 64'(cmd_ready), 64'd0);
    tick();
    check_eq("vl0_cmd_ready_back", 64'(cmd_ready), 64'd1);
    repeat (3) tick();
    check_eq("vl0_nreq", 64'(req_log.size()), 64'd0);
    check_eq("vl0_nbeats", 64'(beat_log.size()), 64'd0);

    // vl=70, all-ones data: tail handling in beat 1
    clear_logs();
    data_ones = 1'b1;
    issue_cmd(32'h70, 32'h80, 32'h90, 16'd70, 3'd6);
    wait_idle(100);
    check_eq("tail_nbeats", 64'(beat_log.size()), 64'd2);
    if (beat_log.size() == 2) begin
      check_eq("tail_beat0_m0", beat_log[0].m0, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef VMASK_TAIL_ZERO_EN
      check_eq("tail_beat1_m0", beat_log[1].m0, 64'h3F);
      check_eq("tail_beat1_m1", beat_log[1].m1, 64'h3F);
`else
      check_eq("tail_beat1_m0", beat_log[1].m0, 64'hFFFF_FFFF_FFFF_FFFF);
      check_eq("tail_beat1_m1", beat_log[1].m1, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    end
    data_ones = 1'b0;

    // Reset during ISSUE with responses pending
    clear_logs();
    resp_en = 1'b0;
    issue_cmd(32'h500, 32'h600, 32'h700, 16'd512, 3'd7);
    repeat (2) tick();
    check_eq("mid_rd_req_valid", 64'(rd_req_valid), 64'd1);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_rd_req_valid", 64'(rd_req_valid), 64'd0);
    check_eq("mid_rst_rd_addr0", 64'(rd_addr0), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
    tick();
    rst = 1'b1;
    #1;
    check_eq("mid_release_cmd_ready", 64'(cmd_ready), 64'd1);
    beat_log.delete();
    resp_en = 1'b1;
    repeat (10) tick();
    check_eq("late_resp_drained", 64'(pend.size()), 64'd0);
    check_eq("late_resp_no_beat", 64'(beat_log.size()), 64'd0);
    check_eq("late_resp_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
